// File: rtl/lsu_mem_access_if.sv
// lsu_mem_access_if: request/response and data-memory bus bundle for lsu_mem_access.
//   req_*  : execute-stage request (valid/ready, we, op, addr, wdata)
//   rsp_*  : one-cycle completion pulse with right-aligned load data and fault flag
//   bus_*  : word-aligned data-memory beat (req held until ack, byte enables)
// Modports: slave = the LSU, master = the execute stage plus the memory side.
interface lsu_mem_access_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic             bus_req;
    logic             bus_we;
    logic [WIDTH-1:0] bus_addr;
    logic [3:0]       bus_be;
    logic [WIDTH-1:0] bus_wdata;
    logic             bus_ack;
    logic [WIDTH-1:0] bus_rdata;

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, bus_ack, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, bus_ack, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: load/store access sequencer between execute and the data-memory bus.
// Accepts one request at a time, issues one (or, if split, two) word-aligned bus beats with
// byte enables, and returns load data right-aligned to bit 0 (upper bits raw, unextended).
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   lsu   : lsu_mem_access_if.slave bundle (req_*, rsp_*, bus_*)
// Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned half/word accesses into two
// beats; otherwise they complete with rsp_err=1 and never touch the bus.
module lsu_mem_access #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_mem_access_if.slave   lsu
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc0 = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [1:0] StAcc1 = 2'd2;
`endif
    localparam logic [1:0] StResp = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       off_q, off_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic             split_q, split_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [3:0]       be_hi_q, be_hi_d;
    logic [WIDTH-1:0] wdata_hi_q, wdata_hi_d;
    logic [2*WIDTH-1:0] rd_cat;
    logic [2*WIDTH-1:0] rd_shift;
    logic             unused_rd;
`else
    logic             unused_hi;
`endif

    logic [1:0]         off;
    logic [7:0]         mask;
    logic [7:0]         mask_sh;
    logic               misaligned;
    logic               fault;
    logic [2*WIDTH-1:0] wdata_sh;
    logic [WIDTH-1:0]   rd_word;
    logic               unused_op;

    assign off       = lsu.req_addr[1:0];
    // Bit 2 of the op only selects sign/zero extension downstream.
    assign unused_op = lsu.req_op[2];

    always_comb begin
        mask       = 8'b0000_1111;
        misaligned = 1'b0;
        unique case (lsu.req_op[1:0])
            2'd0: mask = 8'b0000_0001;
            2'd1: begin
                mask       = 8'b0000_0011;
                misaligned = (off == 2'd3);
            end
            default: begin
                mask       = 8'b0000_1111;
                misaligned = (off != 2'd0);
            end
        endcase
    end

    // Two-word views: low half is beat 0, high half is beat 1 of a split access.
    assign mask_sh  = mask << off;
    assign wdata_sh = {{WIDTH{1'b0}}, lsu.req_wdata} << {off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
    assign fault     = 1'b0;
    assign rd_cat    = (state_q == StAcc1) ? {lsu.bus_rdata, lo_q}
                                           : {{WIDTH{1'b0}}, lsu.bus_rdata};
    assign rd_shift  = rd_cat >> {off_q, 3'b000};
    assign rd_word   = rd_shift[WIDTH-1:0];
    assign unused_rd = ^rd_shift[2*WIDTH-1:WIDTH];
`else
    assign fault     = misaligned;
    assign rd_word   = lsu.bus_rdata >> {off_q, 3'b000};
    assign unused_hi = ^{wdata_sh[2*WIDTH-1:WIDTH], mask_sh[7:4]};
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d     = split_q;
        lo_d        = lo_q;
        be_hi_d     = be_hi_q;
        wdata_hi_d  = wdata_hi_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (lsu.req_valid) begin
                    we_d  = lsu.req_we;
                    off_d = off;
                    if (fault) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = StResp;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = lsu.req_we;
                        bus_addr_d  = {lsu.req_addr[WIDTH-1:2], 2'b00};
                        bus_be_d    = mask_sh[3:0];
                        bus_wdata_d = wdata_sh[WIDTH-1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
                        split_d     = misaligned;
                        be_hi_d     = mask_sh[7:4];
                        wdata_hi_d  = wdata_sh[2*WIDTH-1:WIDTH];
`endif
                        state_d     = StAcc0;
                    end
                end
            end
            StAcc0: begin
                if (lsu.bus_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    lo_d = lsu.bus_rdata;
                    if (split_q) begin
                        // Second beat follows directly; address wraps modulo 2^WIDTH.
                        bus_addr_d  = bus_addr_q + WIDTH'(4);
                        bus_be_d    = be_hi_q;
                        bus_wdata_d = wdata_hi_q;
                        state_d     = StAcc1;
                    end else
`endif
                    begin
                        bus_req_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = we_q ? '0 : rd_word;
                        state_d     = StResp;
                    end
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            StAcc1: begin
                if (lsu.bus_ack) begin
                    bus_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? '0 : rd_word;
                    state_d     = StResp;
                end
            end
`endif
            StResp: begin
                rsp_valid_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            off_q       <= 2'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            lo_q        <= '0;
            be_hi_q     <= 4'd0;
            wdata_hi_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= split_d;
            lo_q        <= lo_d;
            be_hi_q     <= be_hi_d;
            wdata_hi_q  <= wdata_hi_d;
`endif
        end
    end

    assign lsu.req_ready = (state_q == StIdle) && rst_n;
    assign lsu.rsp_valid = rsp_valid_q;
    assign lsu.rsp_err   = rsp_err_q;
    assign lsu.rsp_rdata = rsp_rdata_q;
    assign lsu.bus_req   = bus_req_q;
    assign lsu.bus_we    = bus_we_q;
    assign lsu.bus_addr  = bus_addr_q;
    assign lsu.bus_be    = bus_be_q;
    assign lsu.bus_wdata = bus_wdata_q;

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store access sequencer between the execute stage and the data-memory bus.
- Accepts one load or store request, drives word-aligned bus beats with byte enables, and returns load data right-aligned to bit 0.
- The load-extension stage downstream consumes rsp_rdata and applies sign/zero extension using the same 3-bit op encoding.
- Misaligned accesses either split into two beats or are rejected, controlled by the optional feature.

Parameters:
- WIDTH, 32: data/address width. Only 32 is supported; byte lanes = WIDTH/8 = 4.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  size code: 0/4 byte, 1/5 half, 2/3/6 word; bit 2 ignored here
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  WIDTH  load data right-aligned, upper bits raw (not extended)
- rsp_err  out  1  misalignment fault, valid with rsp_valid
- bus_req  out  1  bus beat request, held until bus_ack
- bus_we  out  1  beat is a write
- bus_addr  out  WIDTH  word-aligned address (bits[1:0] = 0)
- bus_be  out  4  byte enables
- bus_wdata  out  WIDTH  lane-shifted write data
- bus_ack  in  1  beat complete; bus_rdata valid this cycle
- bus_rdata  in  WIDTH  read word

Behaviour:
- Definitions:
  - off = req_addr[1:0]; nbytes = 1/2/4 from req_op[1:0].
  - Misaligned when (half and off==3) or (word and off!=0).
  - Byte accesses are never misaligned.
- States: IDLE, ACC0, ACC1, RESP.
- req_ready = (state==IDLE) and rst_n.
- Handshake: the request is accepted on req_valid & req_ready, which latches we/op/addr/wdata.
  - Aligned, or misaligned with the feature on: go to ACC0.
  - Misaligned with the feature off: go directly to RESP with err=1, no bus beat.
- ACC0: bus_req=1, bus_addr = addr & ~3, bus_be = lane mask for bytes off..min(off+nbytes,4)-1.
  - bus_wdata = wdata << (8*off), low word.
  - bus_req, addr, be, we and wdata are stable until bus_ack.
  - On bus_ack, capture rdata as lo and move to ACC1 if split, else RESP.
- ACC1 (split only): bus_addr = (addr & ~3)+4, bus_be = mask for bytes 0..off+nbytes-5.
  - bus_wdata = high word of {32'b0, wdata} << (8*off).
  - On bus_ack, capture hi and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Loads: rsp_rdata = ({hi,lo} >> 8*off)[31:0]; hi = 0 if there was no split.
  - Stores: rsp_rdata = 0.
- bus_req deasserts the cycle after bus_ack (registered); there are no back-to-back beats without a state change.
- Latency, aligned with zero-wait ack:
  - accept at edge N;
  - bus_req high in cycle N+1;
  - ack in cycle N+1;
  - rsp_valid in cycle N+2.
  - Split access adds one cycle plus wait states. Fault: rsp_valid in cycle N+1.
- Address wrap: addr+4 wraps modulo 2^WIDTH; no fault.
- Reset, all registered outputs: bus_req, bus_we, bus_be, bus_addr, bus_wdata, rsp_valid, rsp_err and rsp_rdata are 0; state is IDLE.
- Reset mid-operation: the beat is abandoned, bus_req is 0 from the next edge, no rsp_valid is produced, and any bus_ack arriving while in IDLE is ignored.
- A new request cannot be accepted in the RESP cycle; req_ready rises the cycle after rsp_valid.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned half/word accesses are split into two beats (ACC0 then ACC1) and complete with rsp_err=0.
- Undefined: ACC1 and the split logic are not compiled; misaligned requests complete in RESP with rsp_err=1, rsp_rdata=0, and no bus_req is ever asserted.

Test Plan:
- Load word op=2 at 0x100, mem[0x100]=0xDEADBEEF, ack with 0 waits -> bus_addr=0x100, be=0xF, rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, err=0.
- Load byte op=4 at 0x103, same memory, ack after 3 wait cycles -> be=0x8, bus_req held 4 cycles, rsp_rdata[7:0]=0xDE.
- Store half op=1 at 0x102, wdata=0x00001234 -> bus_we=1, be=0xC, bus_wdata[31:16]=0x1234, rsp_rdata=0.
- Load word at 0x101, mem[0x100]=0x44332211, mem[0x104]=0x88776655:
  - with LSU_MISALIGN_SPLIT_EN -> beats 0x100/be=0xE then 0x104/be=0x1, rsp_rdata=0x55443322;
  - without it -> no bus_req, rsp_err=1 one cycle after accept.
- Assert rst_n=0 while in ACC0 with ack withheld -> next edge bus_req=0, req_ready=1 after release, no rsp_valid; a late bus_ack is ignored.
- Store word at 0xFFFFFFFE with the split feature on -> second beat bus_addr=0x00000000, be=0x3, completes with no error.
